// File: rtl/irq_csr_unit_pkg.sv
// Shared types and constants for the machine-mode CSR / interrupt unit:
// CSR addresses, interrupt cause codes, CSR op and FSM enums, the CSR file
// record and the read-modify-write helper.
package irq_csr_unit_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MIP     = 12'h344;

   localparam logic [4:0] CAUSE_MSI       = 5'd3;
   localparam logic [4:0] CAUSE_MTI       = 5'd7;
   localparam logic [4:0] CAUSE_MEI       = 5'd11;
   localparam logic [4:0] CAUSE_PLAT_BASE = 5'd16;

   typedef enum logic [1:0] {
      CSR_READ  = 2'd0,
      CSR_WRITE = 2'd1,
      CSR_SET   = 2'd2,
      CSR_CLEAR = 2'd3
   } csr_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } irq_state_e;

   // Priority encoder result: winning interrupt and its cause code.
   typedef struct packed {
      logic       valid;
      logic [4:0] cause;
   } prio_t;

   // Stateful part of the CSR file. mip_plat holds only the latched platform
   // pending bits at their architectural positions; bits 3/7/11 are live lines.
   typedef struct packed {
      logic        mstatus_mie;
      logic        mstatus_mpie;
      logic [31:0] mie;
      logic [31:0] mip_plat;
      logic [31:0] mtvec;
      logic [31:0] mepc;
      logic [31:0] mcause;
   } csr_file_t;

   // New value produced by a CSR instruction from the old value and operand.
   function automatic logic [31:0] csr_apply(input csr_op_e op,
                                             input logic [31:0] old_val,
                                             input logic [31:0] operand);
      logic [31:0] res;
      case (op)
         CSR_WRITE: res = operand;
         CSR_SET:   res = old_val | operand;
         CSR_CLEAR: res = old_val & ~operand;
         default:   res = old_val;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/irq_csr_unit_if.sv
// Bus between the control unit (master) and the CSR / interrupt unit (slave):
// CSR access port, exception/mret events, interrupt handshake and targets.
interface irq_csr_unit_if;
   logic        csr_en;
   logic [1:0]  csr_op;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        csr_illegal;
   logic        trap_valid;
   logic [3:0]  trap_cause;
   logic [31:0] trap_pc;
   logic        mret_valid;
   logic        irq_req;
   logic        irq_ack;
   logic [31:0] irq_pc;
   logic [31:0] trap_target;
   logic [31:0] mret_target;

   modport master (
      output csr_en, csr_op, csr_addr, csr_wdata,
      output trap_valid, trap_cause, trap_pc, mret_valid, irq_ack, irq_pc,
      input  csr_rdata, csr_illegal, irq_req, trap_target, mret_target
   );

   modport slave (
      input  csr_en, csr_op, csr_addr, csr_wdata,
      input  trap_valid, trap_cause, trap_pc, mret_valid, irq_ack, irq_pc,
      output csr_rdata, csr_illegal, irq_req, trap_target, mret_target
   );
endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority interrupt encoder: MEI > MSI > MTI > platform lines, with
// the lowest platform index winning among platform lines.
module irq_prio_enc
   import irq_csr_unit_pkg::*;
#(
   parameter int N_PLAT = 4
) (
   input  logic              msi_i,
   input  logic              mti_i,
   input  logic              mei_i,
   input  logic [N_PLAT-1:0] plat_i,
   output prio_t             prio_o
);

   // Later assignments override earlier ones, so lower-priority sources go first.
   always_comb begin
      prio_o = '0;
      for (int i = N_PLAT - 1; i >= 0; i--) begin
         if (plat_i[i]) begin
            prio_o.valid = 1'b1;
            prio_o.cause = CAUSE_PLAT_BASE + 5'(i);
         end
      end
      if (mti_i) begin
         prio_o.valid = 1'b1;
         prio_o.cause = CAUSE_MTI;
      end
      if (msi_i) begin
         prio_o.valid = 1'b1;
         prio_o.cause = CAUSE_MSI;
      end
      if (mei_i) begin
         prio_o.valid = 1'b1;
         prio_o.cause = CAUSE_MEI;
      end
   end

endmodule

// File: rtl/irq_csr_unit.sv
// Machine-mode CSR file and interrupt controller. Holds mstatus/mie/mip/
// mtvec/mepc/mcause, latches platform interrupt edges, arbitrates pending
// interrupts and runs a held request/acknowledge handshake.
module irq_csr_unit
   import irq_csr_unit_pkg::*;
#(
   parameter int          N_PLAT      = 4,
   parameter bit          VECTORED_EN = 1'b1,
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              irq_msi_i,
   input  logic              irq_mti_i,
   input  logic              irq_mei_i,
   input  logic [N_PLAT-1:0] irq_plat_i,
   irq_csr_unit_if.slave     bus
);

   localparam logic [31:0] PLAT_MASK = ((32'd1 << N_PLAT) - 32'd1) << 16;
   localparam logic [31:0] MIE_MASK  = 32'h0000_0888 | PLAT_MASK;

   csr_file_t         csr_q, csr_d;
   irq_state_e        state_q, state_d;
   logic [N_PLAT-1:0] plat_q;

   logic [N_PLAT-1:0] plat_rise;
   logic [31:0]       plat_rise_w;
   logic [31:0]       mip_rd;
   logic [31:0]       mstatus_rd;
   logic [31:0]       csr_old;
   logic              addr_ok;
   logic [31:0]       wr_val;
   logic              csr_wr;
   logic              ack_take;
   logic              q_msi, q_mti, q_mei;
   logic [N_PLAT-1:0] q_plat;
   prio_t             prio;
   logic [31:0]       base;
   logic [31:0]       vec_off;
   logic [1:0]        mtvec_mode;

   assign plat_rise   = irq_plat_i & ~plat_q;
   assign plat_rise_w = 32'(plat_rise) << 16;

   assign mip_rd     = csr_q.mip_plat |
                       {20'd0, irq_mei_i, 3'd0, irq_mti_i, 3'd0, irq_msi_i, 3'd0};
   assign mstatus_rd = {24'd0, csr_q.mstatus_mpie, 3'd0, csr_q.mstatus_mie, 3'd0};

   // Qualified pending sources: mip & mie, gated by the global enable.
   assign q_msi  = irq_msi_i & csr_q.mie[3]  & csr_q.mstatus_mie;
   assign q_mti  = irq_mti_i & csr_q.mie[7]  & csr_q.mstatus_mie;
   assign q_mei  = irq_mei_i & csr_q.mie[11] & csr_q.mstatus_mie;
   assign q_plat = csr_q.mip_plat[16 +: N_PLAT] & csr_q.mie[16 +: N_PLAT] &
                   {N_PLAT{csr_q.mstatus_mie}};

   irq_prio_enc #(.N_PLAT(N_PLAT)) u_prio (
      .msi_i  (q_msi),
      .mti_i  (q_mti),
      .mei_i  (q_mei),
      .plat_i (q_plat),
      .prio_o (prio)
   );

   // CSR read mux and address decode.
   always_comb begin
      csr_old = '0;
      addr_ok = 1'b1;
      case (bus.csr_addr)
         CSR_MSTATUS: csr_old = mstatus_rd;
         CSR_MIE:     csr_old = csr_q.mie;
         CSR_MTVEC:   csr_old = csr_q.mtvec;
         CSR_MEPC:    csr_old = csr_q.mepc;
         CSR_MCAUSE:  csr_old = csr_q.mcause;
         CSR_MIP:     csr_old = mip_rd;
         default:     addr_ok = 1'b0;
      endcase
   end

   assign bus.csr_rdata   = (bus.csr_en && addr_ok) ? csr_old : 32'd0;
   assign bus.csr_illegal = bus.csr_en && !addr_ok;

   assign wr_val   = csr_apply(csr_op_e'(bus.csr_op), csr_old, bus.csr_wdata);
   assign csr_wr   = bus.csr_en && addr_ok && (csr_op_e'(bus.csr_op) != CSR_READ);
   // An acknowledge only counts while a request is actually being held.
   assign ack_take = bus.irq_ack && (state_q == ST_REQ) && prio.valid;

   // CSR next state: trap > interrupt ack > mret > CSR instruction.
   always_comb begin
      logic [31:0] plat_keep;
      csr_d     = csr_q;
      plat_keep = csr_q.mip_plat;
      mtvec_mode = wr_val[1:0];
      if (bus.trap_valid) begin
         csr_d.mepc         = bus.trap_pc & ~32'd3;
         csr_d.mcause       = 32'(bus.trap_cause);
         csr_d.mstatus_mpie = csr_q.mstatus_mie;
         csr_d.mstatus_mie  = 1'b0;
      end else if (ack_take) begin
         csr_d.mepc         = bus.irq_pc & ~32'd3;
         csr_d.mcause       = {1'b1, 26'd0, prio.cause};
         csr_d.mstatus_mpie = csr_q.mstatus_mie;
         csr_d.mstatus_mie  = 1'b0;
      end else if (bus.mret_valid) begin
         csr_d.mstatus_mie  = csr_q.mstatus_mpie;
         csr_d.mstatus_mpie = 1'b1;
      end else if (csr_wr) begin
         case (bus.csr_addr)
            CSR_MSTATUS: begin
               csr_d.mstatus_mie  = wr_val[3];
               csr_d.mstatus_mpie = wr_val[7];
            end
            CSR_MIE:    csr_d.mie = wr_val & MIE_MASK;
            CSR_MTVEC: begin
               // Reserved modes, or vectored when not supported, fall back to direct.
               if (mtvec_mode == 2'b00 || (mtvec_mode == 2'b01 && VECTORED_EN))
                  csr_d.mtvec = wr_val;
               else
                  csr_d.mtvec = {wr_val[31:2], 2'b00};
            end
            CSR_MEPC:   csr_d.mepc   = wr_val & ~32'd3;
            CSR_MCAUSE: csr_d.mcause = wr_val;
            // Platform pending bits can only be cleared by software.
            CSR_MIP:    plat_keep = csr_q.mip_plat & wr_val;
            default:    ;
         endcase
      end
      // A new edge wins over a simultaneous software clear.
      csr_d.mip_plat = (plat_keep | plat_rise_w) & PLAT_MASK;
   end

   // Handshake FSM next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (prio.valid && !bus.trap_valid) state_d = ST_REQ;
         ST_REQ:  if (bus.irq_ack || !prio.valid)    state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         csr_q       <= '0;
         csr_q.mtvec <= MTVEC_RESET;
         state_q     <= ST_IDLE;
         plat_q      <= '0;
      end else begin
         csr_q   <= csr_d;
         state_q <= state_d;
         plat_q  <= irq_plat_i;
      end
   end

   assign bus.irq_req     = (state_q == ST_REQ);
   assign base            = {csr_q.mtvec[31:2], 2'b00};
   assign vec_off         = {25'd0, prio.cause, 2'b00};
   assign bus.trap_target = (VECTORED_EN && csr_q.mtvec[1:0] == 2'b01 &&
                             state_q == ST_REQ && !bus.trap_valid) ? base + vec_off : base;
   assign bus.mret_target = csr_q.mepc;

endmodule

// File: tb/tb_irq_csr_unit.sv
// Directed testbench for irq_csr_unit: reset values, vectored MEI, MTI with a
// platform edge, retraction, trap/ack collision, mret and reset during REQ.
module tb_irq_csr_unit;
   import irq_csr_unit_pkg::*;

   localparam logic [31:0] MTVEC_RST = 32'h0000_1000;

   logic       clk;
   logic       rst;
   logic       irq_msi, irq_mti, irq_mei;
   logic [3:0] irq_plat;
   int         errors;
   int         checks;
   logic [31:0] rd;

   irq_csr_unit_if bus_if ();

   irq_csr_unit #(
      .N_PLAT      (4),
      .VECTORED_EN (1'b1),
      .MTVEC_RESET (MTVEC_RST)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .irq_msi_i  (irq_msi),
      .irq_mti_i  (irq_mti),
      .irq_mei_i  (irq_mei),
      .irq_plat_i (irq_plat),
      .bus        (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One CSR instruction occupying one cycle; returns the combinational read value.
   task automatic csr_access(input logic [1:0] op, input logic [11:0] addr,
                             input logic [31:0] wdata, output logic [31:0] rdata);
      bus_if.csr_en    = 1'b1;
      bus_if.csr_op    = op;
      bus_if.csr_addr  = addr;
      bus_if.csr_wdata = wdata;
      #2;
      rdata = bus_if.csr_rdata;
      $display("csr op=%0d addr=%h wdata=%h rdata=%h", op, addr, wdata, rdata);
      step();
      bus_if.csr_en = 1'b0;
   endtask

   task automatic csr_read_check(input string tag, input logic [11:0] addr, input logic [31:0] exp);
      logic [31:0] v;
      csr_access(CSR_READ, addr, 32'd0, v);
      check_value(tag, v, exp);
   endtask

   task automatic csr_write(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata);
      logic [31:0] v;
      csr_access(op, addr, wdata, v);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b0;
      irq_msi = 1'b0; irq_mti = 1'b0; irq_mei = 1'b0; irq_plat = 4'd0;
      bus_if.csr_en = 1'b0; bus_if.csr_op = 2'd0; bus_if.csr_addr = 12'd0; bus_if.csr_wdata = 32'd0;
      bus_if.trap_valid = 1'b0; bus_if.trap_cause = 4'd0; bus_if.trap_pc = 32'd0;
      bus_if.mret_valid = 1'b0; bus_if.irq_ack = 1'b0; bus_if.irq_pc = 32'd0;
      repeat (3) step();
      rst = 1'b1;

      // Reset values
      check_value("rst_irq_req", 32'(bus_if.irq_req), 32'd0);
      check_value("rst_trap_target_direct", bus_if.trap_target, MTVEC_RST);
      csr_read_check("rst_mstatus", CSR_MSTATUS, 32'd0);
      csr_read_check("rst_mie", CSR_MIE, 32'd0);
      csr_read_check("rst_mtvec", CSR_MTVEC, MTVEC_RST);
      csr_read_check("rst_mepc", CSR_MEPC, 32'd0);
      csr_read_check("rst_mcause", CSR_MCAUSE, 32'd0);
      csr_read_check("rst_mip", CSR_MIP, 32'd0);
      bus_if.csr_en = 1'b1; bus_if.csr_op = CSR_READ; bus_if.csr_addr = 12'h123;
      #1;
      check_value("illegal_flag", 32'(bus_if.csr_illegal), 32'd1);
      check_value("illegal_rdata", bus_if.csr_rdata, 32'd0);
      bus_if.csr_en = 1'b0;
      step();

      // Vectored MEI
      csr_write(CSR_WRITE, CSR_MTVEC, 32'h101);
      csr_read_check("mtvec_vectored", CSR_MTVEC, 32'h101);
      csr_write(CSR_WRITE, CSR_MIE, 32'h800);
      csr_write(CSR_WRITE, CSR_MSTATUS, 32'h8);
      irq_mei = 1'b1;
      #1;
      check_value("mei_req_not_yet", 32'(bus_if.irq_req), 32'd0);
      step();
      check_value("mei_req", 32'(bus_if.irq_req), 32'd1);
      check_value("mei_vec_target", bus_if.trap_target, 32'h12C);
      bus_if.irq_ack = 1'b1; bus_if.irq_pc = 32'h40;
      step();
      bus_if.irq_ack = 1'b0;
      $display("ack mei irq_pc=%h", 32'h40);
      check_value("mei_req_drop", 32'(bus_if.irq_req), 32'd0);
      csr_read_check("mei_mepc", CSR_MEPC, 32'h40);
      csr_read_check("mei_mcause", CSR_MCAUSE, 32'h8000_000B);
      csr_read_check("mei_mstatus", CSR_MSTATUS, 32'h80);
      irq_mei = 1'b0;

      // MTI and platform line 0
      csr_write(CSR_WRITE, CSR_MIE, 32'h10080);
      irq_mti = 1'b1;
      irq_plat = 4'b0001;
      step();
      irq_plat = 4'b0000;
      csr_read_check("plat_latched", CSR_MIP, 32'h10080);
      csr_write(CSR_WRITE, CSR_MSTATUS, 32'h8);
      step();
      check_value("mti_req", 32'(bus_if.irq_req), 32'd1);
      check_value("mti_vec_target", bus_if.trap_target, 32'h11C);
      bus_if.irq_ack = 1'b1; bus_if.irq_pc = 32'h44;
      step();
      bus_if.irq_ack = 1'b0;
      $display("ack mti irq_pc=%h", 32'h44);
      csr_read_check("mti_mcause", CSR_MCAUSE, 32'h8000_0007);
      csr_read_check("mti_mepc", CSR_MEPC, 32'h44);
      irq_mti = 1'b0;
      csr_read_check("plat_still_pending", CSR_MIP, 32'h10000);
      csr_write(CSR_WRITE, CSR_MIP, 32'h10000);
      csr_read_check("mip_write1_no_set", CSR_MIP, 32'h10000);
      csr_write(CSR_CLEAR, CSR_MIP, 32'h10000);
      csr_read_check("plat_cleared", CSR_MIP, 32'd0);
      csr_write(CSR_WRITE, CSR_MSTATUS, 32'h8);
      step();
      check_value("no_rerequest", 32'(bus_if.irq_req), 32'd0);

      // Retraction
      irq_mti = 1'b1;
      step();
      check_value("retract_req_up", 32'(bus_if.irq_req), 32'd1);
      csr_write(CSR_CLEAR, CSR_MIE, 32'h80);
      step();
      check_value("retract_req_down", 32'(bus_if.irq_req), 32'd0);
      csr_read_check("retract_mcause", CSR_MCAUSE, 32'h8000_0007);
      irq_mti = 1'b0;

      // trap_valid together with irq_ack
      csr_write(CSR_WRITE, CSR_MIE, 32'h800);
      irq_mei = 1'b1;
      step();
      check_value("trapack_req_up", 32'(bus_if.irq_req), 32'd1);
      bus_if.trap_valid = 1'b1; bus_if.trap_cause = 4'd2; bus_if.trap_pc = 32'h80;
      bus_if.irq_ack = 1'b1; bus_if.irq_pc = 32'h99C;
      #1;
      check_value("trap_target_base", bus_if.trap_target, 32'h100);
      step();
      bus_if.trap_valid = 1'b0; bus_if.irq_ack = 1'b0;
      $display("trap cause=2 pc=%h with ack", 32'h80);
      step();
      check_value("trapack_req_low", 32'(bus_if.irq_req), 32'd0);
      csr_read_check("trap_mcause", CSR_MCAUSE, 32'd2);
      csr_read_check("trap_mepc", CSR_MEPC, 32'h80);
      csr_read_check("trap_mstatus", CSR_MSTATUS, 32'h80);
      csr_read_check("trap_mip_pending", CSR_MIP, 32'h800);
      irq_mei = 1'b0;

      // mtvec illegal mode, mepc alignment, mret beating a CSR write
      csr_write(CSR_WRITE, CSR_MTVEC, 32'h103);
      csr_read_check("mtvec_bad_mode", CSR_MTVEC, 32'h100);
      csr_write(CSR_WRITE, CSR_MEPC, 32'h203);
      csr_read_check("mepc_align", CSR_MEPC, 32'h200);
      check_value("mret_target", bus_if.mret_target, 32'h200);
      bus_if.mret_valid = 1'b1;
      csr_access(CSR_WRITE, CSR_MCAUSE, 32'h55, rd);
      bus_if.mret_valid = 1'b0;
      csr_read_check("mret_mstatus", CSR_MSTATUS, 32'h88);
      csr_read_check("mret_drops_csr_write", CSR_MCAUSE, 32'd2);

      // Reset while requesting
      irq_mei = 1'b1;
      step();
      check_value("rstreq_req_up", 32'(bus_if.irq_req), 32'd1);
      rst = 1'b0;
      step();
      check_value("rstreq_req_low", 32'(bus_if.irq_req), 32'd0);
      rst = 1'b1;
      irq_mei = 1'b0;
      csr_read_check("rst2_mstatus", CSR_MSTATUS, 32'd0);
      csr_read_check("rst2_mie", CSR_MIE, 32'd0);
      csr_read_check("rst2_mtvec", CSR_MTVEC, MTVEC_RST);
      csr_read_check("rst2_mepc", CSR_MEPC, 32'd0);
      csr_read_check("rst2_mcause", CSR_MCAUSE, 32'd0);
      csr_read_check("rst2_mip", CSR_MIP, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/irq_csr_unit.md
# irq_csr_unit

Machine-mode CSR and interrupt controller for the RISC-V core. It holds mstatus, mie, mip, mtvec, mepc and mcause, and arbitrates among software, timer, external and N_PLAT platform interrupt lines. It raises a held request/acknowledge handshake toward the control unit and computes direct or vectored trap targets. It sits beside the control unit and replaces the fixed-width, interrupt-only CSR record with a parametrised, stateful block.

## Interface
- N_PLAT, 4: platform interrupt lines, mapped to mip/mie bits 16..16+N_PLAT-1; 1..16.
- VECTORED_EN, 1: 1 allows mtvec mode 1 (vectored); 0 forces direct mode.
- MTVEC_RESET, 32'h0000_0000: reset value of mtvec.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- irq_msi / irq_mti / irq_mei  in  1 each  level-sensitive software / timer / external lines.
- irq_plat  in  N_PLAT  rising-edge platform lines.
- csr_en  in  1  CSR access this cycle.
- csr_op  in  2  0 read, 1 write, 2 set, 3 clear.
- csr_addr  in  12  CSR address.
- csr_wdata  in  32  operand.
- csr_rdata  out  32  combinational old value; 0 when idle or illegal.
- csr_illegal  out  1  combinational; csr_en with an unimplemented address.
- trap_valid  in  1  synchronous exception, single cycle.
- trap_cause  in  4  exception code.
- trap_pc  in  32  faulting PC.
- mret_valid  in  1  mret retiring.
- irq_req  out  1  registered interrupt request.
- irq_ack  in  1  control unit takes the interrupt.
- irq_pc  in  32  PC to save on ack.
- trap_target  out  32  combinational handler address.
- mret_target  out  32  equals mepc.

## Operation
- Implemented CSRs:
  - mstatus 0x300: bits MIE[3] and MPIE[7] only; other bits read 0.
  - mie 0x304: mask 0x888 | platform bits.
  - mtvec 0x305: BASE[31:2] and MODE[1:0]; MODE write ≠0,1, or 1 with VECTORED_EN=0, stores 0.
  - mepc 0x341: bits [1:0] forced 0.
  - mcause 0x342.
  - mip 0x344: bits 3/7/11 read-only live lines; platform bits are writable only by clear, or by write with 0.
- Platform pending: bit set on a 0→1 edge of irq_plat (input registered once); stays set until cleared by CSR. If a set and a clear occur in the same cycle, the set wins.
- Qualified pending: `mip & mie & {32{mstatus.MIE}}`.
- Priority: MEI(11) > MSI(3) > MTI(7) > platform, lowest index highest. Platform cause = 16+i.
- FSM:
  - IDLE→REQ when qualified pending ≠0 and not trap_valid.
  - REQ→IDLE on irq_ack, or when qualified pending becomes 0 (retraction allowed).
  - irq_req = (state==REQ).
- Ack edge: mepc←irq_pc; mcause←{1,cause of winner at ack}; MPIE←MIE; MIE←0. Platform bits are not auto-cleared.
- trap_valid: mepc←trap_pc; mcause←{0,trap_cause}; MPIE←MIE; MIE←0.
- mret_valid: MIE←MPIE; MPIE←1.
- trap_target:
  - direct: {BASE,2'b0}.
  - vectored and REQ: base + 4·cause.
  - exceptions: always base.
- Arithmetic is 32-bit modulo.

## Timing
- Reset: mstatus, mie, mepc, mcause, platform pending = 0; mtvec = MTVEC_RESET; state IDLE; irq_req 0. Reset mid-REQ drops irq_req at that edge.
- irq_req rises 1 cycle after a qualified pending line is seen; 2 cycles after a platform edge.
- CSR writes take effect at the next edge; reads return the pre-write value.
- Precedence in one cycle: trap_valid > irq_ack > mret_valid > CSR write.
  - A losing CSR write is dropped.
  - trap_valid with irq_ack: the exception is recorded and the interrupt stays pending in mip; with MIE now 0, irq_req falls next cycle.
- irq_ack while IDLE is ignored.

## Structure
- Shared package: extended CSRfileType, CSR address constants, cause codes, csr_op enum, FSM state enum.
- Sub-module irq_prio_enc: combinational, N_PLAT-parametrised priority encoder outputting {valid, cause[4:0]}.

## Test plan
- Reset and read all CSRs: mtvec=MTVEC_RESET, others 0, irq_req 0.
- Vectored MEI:
  - Setup: mtvec=0x101, mie=0x800, mstatus=0x8; then irq_mei=1.
  - Next cycle: irq_req=1, trap_target=0x12C.
  - Ack with irq_pc=0x40: mepc=0x40, mcause=0x8000000B, mstatus=0x80; irq_req=0 next cycle.
- MTI and platform:
  - Setup: irq_mti and a 1-cycle pulse on irq_plat[0], both enabled.
  - Expected: cause 7 taken; mip[16] stays 1.
  - Clear with csr clear 0x10000: mip[16]=0, no re-request.
- Retraction: in REQ, clear mie → irq_req=0 next cycle, mcause unchanged.
- trap_valid with irq_ack, trap_cause=2, trap_pc=0x80: mcause=2, mepc=0x80, trap_target=base.
- mret with mepc=0x200, MPIE=1: mret_target=0x200, mstatus.MIE=1.
- rst low during REQ: irq_req=0 and all CSRs at reset values next cycle.
